// File: rtl/lattice_frame_renderer_if.sv
// Bundle between the frame renderer, the lattice core read port and the VGA frame buffer write port.
// The renderer takes the master modport; the core/frame-buffer side takes slave.
interface lattice_frame_renderer_if;
  logic        start;
  logic [11:0] index;
  logic [6:0]  data;
  logic [18:0] wr_addr;
  logic [6:0]  wr_data;
  logic        wr_en;
  logic        busy;
  logic        done;
  logic [15:0] frame_cnt;

  modport master (
    input  start, data,
    output index, wr_addr, wr_data, wr_en, busy, done, frame_cnt
  );

  modport slave (
    output start, data,
    input  index, wr_addr, wr_data, wr_en, busy, done, frame_cnt
  );
endinterface

// File: rtl/lattice_frame_renderer.sv
// Scans every lattice node once per start pulse and paints it as a CELL_PX square into the frame buffer.
// Optional feature: define DRAW_GRID_LINES_EN to paint the top/left pixel row/column of each cell as grid lines.
module lattice_frame_renderer #(
  parameter int GRID_W   = 50,
  parameter int GRID_H   = 50,
  parameter int CELL_PX  = 8,
  parameter int SCREEN_W = 640,
  parameter int X_OFF    = 0,
  parameter int Y_OFF    = 0
) (
  input  logic                       clk_50,
  input  logic                       reset,
  lattice_frame_renderer_if.master   bus
);

  localparam int CW = (GRID_W  > 1) ? $clog2(GRID_W)  : 1;
  localparam int RW = (GRID_H  > 1) ? $clog2(GRID_H)  : 1;
  localparam int PW = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;

  localparam logic [CW-1:0] COL_LAST    = CW'(GRID_W - 1);
  localparam logic [RW-1:0] ROW_LAST    = RW'(GRID_H - 1);
  localparam logic [PW-1:0] PX_LAST     = PW'(CELL_PX - 1);
  localparam logic [18:0]   PITCH       = 19'(SCREEN_W);
  localparam logic [18:0]   CELL_STEP_Y = 19'(CELL_PX * SCREEN_W);
  localparam logic [18:0]   CELL_STEP_X = 19'(CELL_PX);
  localparam logic [18:0]   Y_BASE0     = 19'(Y_OFF * SCREEN_W);
  localparam logic [18:0]   X_BASE0     = 19'(X_OFF);
  localparam logic [11:0]   GRID_STEP   = 12'(GRID_W);

  if (GRID_W < 1 || GRID_H < 1 || X_OFF < 0 || Y_OFF < 0 ||
      (CELL_PX != 1 && CELL_PX != 2 && CELL_PX != 4 && CELL_PX != 8) ||
      SCREEN_W > 640 || GRID_W * GRID_H > 4096 ||
      X_OFF + GRID_W * CELL_PX > SCREEN_W ||
      Y_OFF + GRID_H * CELL_PX > 480) begin : g_bad_cfg
    $error("lattice_frame_renderer: grid does not fit the 640x480 frame buffer");
  end

  typedef enum logic [1:0] {IDLE, FETCH, PAINT, DONE} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [PW-1:0] px_q, px_d, py_q, py_d;
  logic [2:0]  pix_q, pix_d;
  logic [11:0] row_idx_q, row_idx_d;
  logic [18:0] cell_x_q, cell_x_d, cell_y_q, cell_y_d, line_q, line_d;
  logic [11:0] index_q, index_d;
  logic [18:0] wr_addr_q, wr_addr_d;
  logic [6:0]  wr_data_q, wr_data_d;
  logic        wr_en_q, wr_en_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic          paint_n;
  logic [PW-1:0] px_n, py_n;
  logic [18:0]   line_n;
  logic [2:0]    dens_n;

  // Direction bits do not affect the colour.
  logic unused_dir;
  assign unused_dir = ^bus.data[6:3];

  function automatic logic [6:0] node_colour(input logic [2:0] dens);
    return (dens == 3'b111) ? 7'h7F : {dens, 4'b0000};
  endfunction

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    px_d        = px_q;
    py_d        = py_q;
    pix_d       = pix_q;
    row_idx_d   = row_idx_q;
    cell_x_d    = cell_x_q;
    cell_y_d    = cell_y_q;
    line_d      = line_q;
    index_d     = index_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    frame_cnt_d = frame_cnt_q;
    paint_n     = 1'b0;
    px_n        = '0;
    py_n        = '0;
    line_n      = line_q;
    dens_n      = pix_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = FETCH;
          col_d     = '0;
          row_d     = '0;
          row_idx_d = '0;
          cell_x_d  = X_BASE0;
          cell_y_d  = Y_BASE0;
          index_d   = '0;
          busy_d    = 1'b1;
        end
      end
      FETCH: begin
        // The write issued on this edge already needs the colour, so use data directly.
        state_d = PAINT;
        pix_d   = bus.data[2:0];
        paint_n = 1'b1;
        line_n  = cell_y_q;
        dens_n  = bus.data[2:0];
      end
      PAINT: begin
        if (px_q != PX_LAST) begin
          paint_n = 1'b1;
          px_n    = px_q + 1'b1;
          py_n    = py_q;
        end else if (py_q != PX_LAST) begin
          paint_n = 1'b1;
          py_n    = py_q + 1'b1;
          line_n  = line_q + PITCH;
        end else if (col_q == COL_LAST && row_q == ROW_LAST) begin
          state_d     = DONE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end else if (col_q == COL_LAST) begin
          state_d   = FETCH;
          col_d     = '0;
          row_d     = row_q + 1'b1;
          row_idx_d = row_idx_q + GRID_STEP;
          cell_x_d  = X_BASE0;
          cell_y_d  = cell_y_q + CELL_STEP_Y;
          index_d   = row_idx_q + GRID_STEP;
        end else begin
          state_d  = FETCH;
          col_d    = col_q + 1'b1;
          cell_x_d = cell_x_q + CELL_STEP_X;
          index_d  = row_idx_q + 12'(col_q) + 12'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (paint_n) begin
      px_d      = px_n;
      py_d      = py_n;
      line_d    = line_n;
      wr_en_d   = 1'b1;
      wr_addr_d = line_n + cell_x_q + 19'(px_n);
      wr_data_d = node_colour(dens_n);
`ifdef DRAW_GRID_LINES_EN
      if (dens_n != 3'b111 && (px_n == '0 || py_n == '0))
        wr_data_d = 7'h01;
`endif
    end
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      px_q        <= '0;
      py_q        <= '0;
      pix_q       <= '0;
      row_idx_q   <= '0;
      cell_x_q    <= '0;
      cell_y_q    <= '0;
      line_q      <= '0;
      index_q     <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      px_q        <= px_d;
      py_q        <= py_d;
      pix_q       <= pix_d;
      row_idx_q   <= row_idx_d;
      cell_x_q    <= cell_x_d;
      cell_y_q    <= cell_y_d;
      line_q      <= line_d;
      index_q     <= index_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.index     = index_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_lattice_frame_renderer.sv
// Bench for lattice_frame_renderer on a reduced 8x6 grid of 8-pixel cells so full frames stay short.
// Every frame-buffer write is checked against a scoreboard queue filled from a reference model.
module tb_lattice_frame_renderer;

  localparam int GW = 8;
  localparam int GH = 6;
  localparam int CP = 8;
  localparam int SW = 640;
  localparam int NCELLS = GW * GH;
  localparam int FRAME_CYC = NCELLS * (1 + CP * CP);
`ifdef DRAW_GRID_LINES_EN
  localparam bit LINES = 1'b1;
`else
  localparam bit LINES = 1'b0;
`endif

  typedef struct {
    logic [18:0] addr;
    logic [6:0]  data;
  } wr_t;

  typedef struct {
    string       name;
    logic [6:0]  fill;
    int          hot_cell;
    logic [6:0]  hot_val;
    int          probe_addr;
    logic [6:0]  probe_val;
  } vec_t;

  logic clk_50 = 1'b0;
  logic reset  = 1'b1;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   exp_frames = 0;
  int   first_wr_cyc = -1;

  logic [6:0] cell_mem [NCELLS];
  logic [6:0] fb [int];
  wr_t        exp_q [$];
  wr_t        mon_e;
  vec_t       vecs [4];

  lattice_frame_renderer_if bus ();

  lattice_frame_renderer #(
    .GRID_W(GW), .GRID_H(GH), .CELL_PX(CP), .SCREEN_W(SW), .X_OFF(0), .Y_OFF(0)
  ) dut (
    .clk_50 (clk_50),
    .reset  (reset),
    .bus    (bus)
  );

  always #10 clk_50 = ~clk_50;

  always @(posedge clk_50) cyc <= cyc + 1;

  always_comb begin
    bus.data = 7'h00;
    if (int'(bus.index) < NCELLS) bus.data = cell_mem[int'(bus.index)];
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [6:0] modelPixel(input logic [6:0] node, input int px, input int py);
    if (node[2:0] == 3'b111) return 7'h7F;
    if (LINES && (px == 0 || py == 0)) return 7'h01;
    return {node[2:0], 4'h0};
  endfunction

  function automatic vec_t mkVec(input string n, input logic [6:0] fill, input int hot,
                                 input logic [6:0] hv, input int pa, input logic [6:0] pv);
    vec_t v;
    v.name = n; v.fill = fill; v.hot_cell = hot; v.hot_val = hv;
    v.probe_addr = pa; v.probe_val = pv;
    return v;
  endfunction

  // Loads the grid contents and queues every write the frame is expected to produce.
  task automatic loadFrame(input vec_t v);
    wr_t w;
    for (int i = 0; i < NCELLS; i++) cell_mem[i] = v.fill;
    if (v.hot_cell >= 0) cell_mem[v.hot_cell] = v.hot_val;
    exp_q.delete();
    for (int r = 0; r < GH; r++)
      for (int c = 0; c < GW; c++)
        for (int py = 0; py < CP; py++)
          for (int px = 0; px < CP; px++) begin
            w.addr = 19'((r * CP + py) * SW + c * CP + px);
            w.data = modelPixel(cell_mem[r * GW + c], px, py);
            exp_q.push_back(w);
          end
    fb.delete();
    first_wr_cyc = -1;
  endtask

  task automatic pulseStart(output int start_cyc);
    @(negedge clk_50) bus.start = 1'b1;
    @(negedge clk_50) bus.start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic applyStimulus(input vec_t v, input bit poke_busy, input bit poke_done);
    int start_cyc;
    int done_at;
    bit got;
    loadFrame(v);
    pulseStart(start_cyc);
    if (poke_busy) begin
      repeat (200) @(negedge clk_50);
      bus.start = 1'b1;
      @(negedge clk_50) bus.start = 1'b0;
    end
    got = 1'b0;
    done_at = 0;
    for (int i = 0; i < FRAME_CYC + 20; i++) begin
      @(negedge clk_50);
      if (bus.done) begin
        got = 1'b1;
        done_at = cyc;
        break;
      end
    end
    checkOutput({v.name, "/done_seen"}, int'(got), 1);
    if (got) begin
      exp_frames++;
      checkOutput({v.name, "/done_cycle"}, done_at - start_cyc, FRAME_CYC);
      checkOutput({v.name, "/busy_in_done"}, int'(bus.busy), 0);
      checkOutput({v.name, "/frame_cnt"}, int'(bus.frame_cnt), exp_frames);
    end
    checkOutput({v.name, "/first_write_cycle"}, first_wr_cyc - start_cyc, 1);
    if (poke_done) bus.start = 1'b1;
    @(negedge clk_50) bus.start = 1'b0;
    @(negedge clk_50);
    checkOutput({v.name, "/idle_busy"}, int'(bus.busy), 0);
    checkOutput({v.name, "/sb_leftover"}, exp_q.size(), 0);
    checkOutput({v.name, "/probe"}, fb.exists(v.probe_addr) ? int'(fb[v.probe_addr]) : -1,
                int'(v.probe_val));
  endtask

  always @(negedge clk_50) begin
    if (bus.wr_en === 1'b1) begin
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      fb[int'(bus.wr_addr)] = bus.wr_data;
      if (exp_q.size() == 0) begin
        checkOutput("sb_unexpected_write", int'(bus.wr_addr), -1);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("sb_addr", int'(bus.wr_addr), int'(mon_e.addr));
        checkOutput("sb_data", int'(bus.wr_data), int'(mon_e.data));
      end
    end
  end

  initial begin
    int n;
    int sc;
    int done_cnt;
    vecs[0] = mkVec("wall_fill", 7'h07, -1, 7'h00, 0, 7'h7F);
    vecs[1] = mkVec("cell_1_1", 7'h00, GW + 1, 7'h02, 8 * SW + 8, LINES ? 7'h01 : 7'h20);
    vecs[2] = mkVec("dens4_wall_last", 7'h04, NCELLS - 1, 7'h07, SW + 1, 7'h40);
    vecs[3] = mkVec("zero_fill", 7'h00, -1, 7'h00, 0, LINES ? 7'h01 : 7'h00);

    bus.start = 1'b0;
    for (int i = 0; i < NCELLS; i++) cell_mem[i] = 7'h00;

    // Reset held three cycles with a start pulse inside it.
    reset = 1'b1;
    @(negedge clk_50);
    bus.start = 1'b1;
    @(negedge clk_50);
    bus.start = 1'b0;
    @(negedge clk_50);
    checkOutput("rst_index", int'(bus.index), 0);
    checkOutput("rst_wr_addr", int'(bus.wr_addr), 0);
    checkOutput("rst_wr_data", int'(bus.wr_data), 0);
    checkOutput("rst_wr_en", int'(bus.wr_en), 0);
    checkOutput("rst_busy", int'(bus.busy), 0);
    checkOutput("rst_done", int'(bus.done), 0);
    checkOutput("rst_frame_cnt", int'(bus.frame_cnt), 0);
    reset = 1'b0;
    @(negedge clk_50);
    checkOutput("busy_after_reset_start", int'(bus.busy), 0);

    // Reset during the 1000th write aborts the frame without a done pulse.
    loadFrame(mkVec("abort", 7'h03, -1, 7'h00, 0, 7'h30));
    pulseStart(sc);
    n = 0;
    for (int i = 0; i < 2 * FRAME_CYC && n < 1000; i++) begin
      @(negedge clk_50);
      if (bus.wr_en === 1'b1) n++;
    end
    checkOutput("abort_reached_1000", n, 1000);
    reset = 1'b1;
    @(negedge clk_50);
    reset = 1'b0;
    checkOutput("abort_wr_en", int'(bus.wr_en), 0);
    checkOutput("abort_busy", int'(bus.busy), 0);
    checkOutput("abort_done", int'(bus.done), 0);
    checkOutput("abort_frame_cnt", int'(bus.frame_cnt), exp_frames);
    exp_q.delete();
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_50);
      if (bus.done === 1'b1 || bus.wr_en === 1'b1) done_cnt++;
    end
    checkOutput("abort_quiet", done_cnt, 0);

    for (int i = 0; i < 4; i++) applyStimulus(vecs[i], 1'b0, 1'b0);

    // Starts during busy and during DONE are dropped; the next one is taken.
    applyStimulus(vecs[1], 1'b1, 1'b1);
    applyStimulus(vecs[2], 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #(20 * 90000);
    $display("[TB] FAIL watchdog: simulation did not complete within its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
